axis_pkt_fifo: RTL and testbench

Store-and-forward AXI Stream FIFO that holds whole frames and releases a frame to the master side only after its `tlast` beat has been written. It replaces the plain word FIFO on paths that must never present a partial frame downstream, such as migration state streams and checksum/DMA consumers. It also exports occupancy and drop status to the control plane.

---
 rtl/axis_pkt_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_axis_pkt_fifo.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: store-and-forward AXI Stream FIFO holding whole frames.
// A frame becomes visible on the read side only after its tlast beat is stored.
// Build option: define AXIS_PKT_FIFO_DROP_EN to discard frames that do not fit
// (write_tready tied high, frame_drop pulses). Without it the write side is
// back-pressured and an oversize frame falls back to cut-through.
module axis_pkt_fifo #(
   parameter int unsigned AXIS_DATA_WIDTH  = 256,
   parameter int unsigned AXIS_TUSER_WIDTH = 128,
   parameter int unsigned ADDR_WIDTH       = 12
) (
   input  logic                            aclk,
   input  logic                            resetn,

   input  logic [AXIS_DATA_WIDTH-1:0]      write_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0]    write_tkeep,
   input  logic [AXIS_TUSER_WIDTH-1:0]     write_tuser,
   input  logic                            write_tvalid,
   input  logic                            write_tlast,
   output logic                            write_tready,

   output logic [AXIS_DATA_WIDTH-1:0]      read_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0]    read_tkeep,
   output logic [AXIS_TUSER_WIDTH-1:0]     read_tuser,
   output logic                            read_tvalid,
   output logic                            read_tlast,
   input  logic                            read_tready,

   output logic [ADDR_WIDTH:0]             fill_level,
   output logic                            frame_drop
);

   localparam int unsigned KEEP_WIDTH = AXIS_DATA_WIDTH / 8;
   localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;
   localparam int unsigned WORDS      = 2 ** ADDR_WIDTH;
   localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0]  data;
      logic [KEEP_WIDTH-1:0]       keep;
      logic [AXIS_TUSER_WIDTH-1:0] user;
      logic                        last;
   } beat_t;

   // ST_FRAME: normal store-and-forward; ST_CUT: oversize frame streaming
   // through; ST_DROP: discarding the remainder of a frame that did not fit.
   typedef enum logic [1:0] {
      ST_FRAME = 2'd0,
      ST_CUT   = 2'd1,
      ST_DROP  = 2'd2
   } state_t;

   beat_t                 r_mem [WORDS];

   state_t                r_state;
   state_t                w_state_nxt;

   logic [PTR_WIDTH-1:0]  r_wr_ptr;
   logic [PTR_WIDTH-1:0]  r_commit_ptr;
   logic [PTR_WIDTH-1:0]  r_rd_ptr;
   logic [PTR_WIDTH-1:0]  w_wr_ptr_nxt;
   logic [PTR_WIDTH-1:0]  w_commit_ptr_nxt;
   logic [PTR_WIDTH-1:0]  w_rd_ptr_nxt;

   logic                  r_write_tready;
   logic                  r_read_tvalid;
   logic                  r_frame_drop;
   logic [PTR_WIDTH-1:0]  r_fill_level;
   beat_t                 r_out;

   beat_t                 w_wr_beat;
   beat_t                 w_head;
   logic [ADDR_WIDTH-1:0] w_head_addr;
   logic                  w_wr_fire;
   logic                  w_rd_fire;
   logic                  w_full;
   logic                  w_mem_we;
   logic                  w_drop_nxt;
   logic                  w_read_tvalid_nxt;
   logic                  w_write_tready_nxt;

   // Full when the write pointer is a whole lap ahead of the read pointer.
   function automatic logic is_full(input logic [PTR_WIDTH-1:0] wp,
                                    input logic [PTR_WIDTH-1:0] rp);
      return (wp[ADDR_WIDTH-1:0] == rp[ADDR_WIDTH-1:0]) &&
             (wp[ADDR_WIDTH] != rp[ADDR_WIDTH]);
   endfunction

   assign w_wr_beat = {write_tdata, write_tkeep, write_tuser, write_tlast};
   assign w_full    = is_full(r_wr_ptr, r_rd_ptr);
   assign w_wr_fire = write_tvalid & r_write_tready;
   assign w_rd_fire = r_read_tvalid & read_tready;

   // Next-state and next-pointer logic for the write/commit side.
   always_comb begin
      w_state_nxt      = r_state;
      w_wr_ptr_nxt     = r_wr_ptr;
      w_commit_ptr_nxt = r_commit_ptr;
      w_rd_ptr_nxt     = r_rd_ptr + PTR_WIDTH'(w_rd_fire);
      w_mem_we         = 1'b0;
      w_drop_nxt       = 1'b0;
`ifdef AXIS_PKT_FIFO_DROP_EN
      if (w_wr_fire) begin
         case (r_state)
            ST_DROP: begin
               if (write_tlast) begin
                  w_state_nxt = ST_FRAME;
                  w_drop_nxt  = 1'b1;
               end
            end
            default: begin
               if (w_full) begin
                  // No room: forget the partial frame and discard until tlast.
                  w_wr_ptr_nxt = r_commit_ptr;
                  if (write_tlast) begin
                     w_drop_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_DROP;
                  end
               end else begin
                  w_mem_we     = 1'b1;
                  w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                  if (write_tlast) begin
                     w_commit_ptr_nxt = r_wr_ptr + PTR_ONE;
                  end
               end
            end
         endcase
      end
`else
      if (w_wr_fire) begin
         w_mem_we     = 1'b1;
         w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
      end
      case (r_state)
         ST_CUT: begin
            // Cut-through: every stored beat is immediately readable.
            w_commit_ptr_nxt = w_wr_ptr_nxt;
            if (w_wr_fire && write_tlast) begin
               w_state_nxt = ST_FRAME;
            end
         end
         default: begin
            if (w_wr_fire && write_tlast) begin
               w_commit_ptr_nxt = r_wr_ptr + PTR_ONE;
            end else if (w_full && (r_commit_ptr == r_rd_ptr)) begin
               // A single frame fills the whole FIFO: release it to avoid deadlock.
               w_commit_ptr_nxt = w_wr_ptr_nxt;
               w_state_nxt      = ST_CUT;
            end
         end
      endcase
`endif
   end

   // Registered status outputs derived from the next pointer values.
   always_comb begin
      w_read_tvalid_nxt = (w_rd_ptr_nxt != w_commit_ptr_nxt);
`ifdef AXIS_PKT_FIFO_DROP_EN
      w_write_tready_nxt = 1'b1;
`else
      w_write_tready_nxt = ~is_full(w_wr_ptr_nxt, w_rd_ptr_nxt);
`endif
   end

   // Head beat for the next cycle, forwarding a same-edge write to that slot.
   always_comb begin
      w_head_addr = w_rd_ptr_nxt[ADDR_WIDTH-1:0];
      w_head      = r_mem[w_head_addr];
      if (w_mem_we && (r_wr_ptr[ADDR_WIDTH-1:0] == w_head_addr)) begin
         w_head = w_wr_beat;
      end
   end

   // Beat storage: synchronous write, asynchronous read.
   always_ff @(posedge aclk) begin
      if (resetn && w_mem_we) begin
         r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_wr_beat;
      end
   end

   // State, pointers and registered outputs.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         r_state        <= ST_FRAME;
         r_wr_ptr       <= '0;
         r_commit_ptr   <= '0;
         r_rd_ptr       <= '0;
         r_write_tready <= 1'b1;
         r_read_tvalid  <= 1'b0;
         r_frame_drop   <= 1'b0;
         r_fill_level   <= '0;
         r_out          <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_wr_ptr       <= w_wr_ptr_nxt;
         r_commit_ptr   <= w_commit_ptr_nxt;
         r_rd_ptr       <= w_rd_ptr_nxt;
         r_write_tready <= w_write_tready_nxt;
         r_read_tvalid  <= w_read_tvalid_nxt;
         r_frame_drop   <= w_drop_nxt;
         r_fill_level   <= w_commit_ptr_nxt - w_rd_ptr_nxt;
         if (w_read_tvalid_nxt) begin
            r_out <= w_head;
         end
      end
   end

   assign write_tready = r_write_tready;
   assign read_tvalid  = r_read_tvalid;
   assign read_tdata   = r_out.data;
   assign read_tkeep   = r_out.keep;
   assign read_tuser   = r_out.user;
   assign read_tlast   = r_out.last;
   assign fill_level   = r_fill_level;
   assign frame_drop   = r_frame_drop;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: queue-based reference model plus directed and random frames.
`timescale 1ns/1ps
module tb_axis_pkt_fifo;

   localparam int unsigned DW    = 32;
   localparam int unsigned UW    = 8;
   localparam int unsigned KW    = DW / 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned WORDS = 2 ** AW;
`ifdef AXIS_PKT_FIFO_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   logic          aclk = 1'b0;
   logic          resetn = 1'b0;
   logic [DW-1:0] write_tdata = '0;
   logic [KW-1:0] write_tkeep = '0;
   logic [UW-1:0] write_tuser = '0;
   logic          write_tvalid = 1'b0;
   logic          write_tlast = 1'b0;
   logic          write_tready;
   logic [DW-1:0] read_tdata;
   logic [KW-1:0] read_tkeep;
   logic [UW-1:0] read_tuser;
   logic          read_tvalid;
   logic          read_tlast;
   logic          read_tready = 1'b0;
   logic [AW:0]   fill_level;
   logic          frame_drop;

   always #5 aclk = ~aclk;

   axis_pkt_fifo #(
      .AXIS_DATA_WIDTH (DW),
      .AXIS_TUSER_WIDTH(UW),
      .ADDR_WIDTH      (AW)
   ) dut (
      .aclk        (aclk),
      .resetn      (resetn),
      .write_tdata (write_tdata),
      .write_tkeep (write_tkeep),
      .write_tuser (write_tuser),
      .write_tvalid(write_tvalid),
      .write_tlast (write_tlast),
      .write_tready(write_tready),
      .read_tdata  (read_tdata),
      .read_tkeep  (read_tkeep),
      .read_tuser  (read_tuser),
      .read_tvalid (read_tvalid),
      .read_tlast  (read_tlast),
      .read_tready (read_tready),
      .fill_level  (fill_level),
      .frame_drop  (frame_drop)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   bit          chk_en   = 1'b0;
   int unsigned vprob    = 100;
   int unsigned rprob    = 0;
   int unsigned seq      = 0;
   beat_t       tx_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: committed beats are readable, pending beats belong to
   // the frame still being written.
   beat_t m_comm[$];
   beat_t m_pend[$];
   bit    m_cut   = 1'b0;
   bit    m_drop  = 1'b0;
   bit    m_pulse = 1'b0;

   function automatic bit exp_wready();
      return DROP || ((m_comm.size() + m_pend.size()) < int'(WORDS));
   endfunction

   // Compare DUT against the model, then advance the model by the coming edge.
   always @(negedge aclk) begin : cmp
      int  stored;
      bit  full_pre, comm_empty_pre, wrdy, pulse;
      beat_t b;
      if (chk_en) begin
         chk("write_tready", 64'(write_tready), 64'(exp_wready()));
         chk("read_tvalid",  64'(read_tvalid),  64'(m_comm.size() > 0));
         chk("fill_level",   64'(fill_level),   64'(m_comm.size()));
         chk("frame_drop",   64'(frame_drop),   64'(m_pulse));
         if (m_comm.size() > 0) begin
            chk("read_tdata", 64'(read_tdata), 64'(m_comm[0].data));
            chk("read_tkeep", 64'(read_tkeep), 64'(m_comm[0].keep));
            chk("read_tuser", 64'(read_tuser), 64'(m_comm[0].user));
            chk("read_tlast", 64'(read_tlast), 64'(m_comm[0].last));
         end
      end
      if (!resetn) begin
         m_comm.delete();
         m_pend.delete();
         m_cut   = 1'b0;
         m_drop  = 1'b0;
         m_pulse = 1'b0;
      end else begin
         stored         = m_comm.size() + m_pend.size();
         full_pre       = stored >= int'(WORDS);
         comm_empty_pre = (m_comm.size() == 0);
         wrdy           = exp_wready();
         pulse          = 1'b0;
         b              = {write_tdata, write_tkeep, write_tuser, write_tlast};
         if (!comm_empty_pre && read_tready) void'(m_comm.pop_front());
         if (DROP) begin
            if (write_tvalid) begin
               if (m_drop) begin
                  if (b.last) begin m_drop = 1'b0; pulse = 1'b1; end
               end else if (full_pre) begin
                  m_pend.delete();
                  if (b.last) pulse = 1'b1;
                  else        m_drop = 1'b1;
               end else begin
                  m_pend.push_back(b);
                  if (b.last) begin
                     foreach (m_pend[i]) m_comm.push_back(m_pend[i]);
                     m_pend.delete();
                  end
               end
            end
         end else begin
            if (write_tvalid && wrdy) begin
               if (m_cut) begin
                  m_comm.push_back(b);
                  if (b.last) m_cut = 1'b0;
               end else begin
                  m_pend.push_back(b);
                  if (b.last) begin
                     foreach (m_pend[i]) m_comm.push_back(m_pend[i]);
                     m_pend.delete();
                  end
               end
            end else if (!m_cut && full_pre && comm_empty_pre) begin
               m_cut = 1'b1;
               foreach (m_pend[i]) m_comm.push_back(m_pend[i]);
               m_pend.delete();
            end
         end
         m_pulse = pulse;
      end
   end

   // Handshake bookkeeping used by the stimulus and the directed checks.
   bit wr_acc   = 1'b0;
   int rd_cnt   = 0;
   int last_cnt = 0;
   int drop_cnt = 0;
   always @(posedge aclk) begin
      wr_acc <= resetn & write_tvalid & write_tready;
      if (resetn === 1'b1 && read_tvalid === 1'b1 && read_tready) begin
         rd_cnt <= rd_cnt + 1;
         if (read_tlast) last_cnt <= last_cnt + 1;
      end
      if (resetn === 1'b1 && frame_drop === 1'b1) drop_cnt <= drop_cnt + 1;
   end

   function automatic beat_t mk(input logic [DW-1:0] d, input bit last);
      beat_t b;
      b.data = d;
      b.keep = '1;
      b.user = d[UW-1:0];
      b.last = last;
      return b;
   endfunction

   task automatic push_frame(input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         seq++;
         b.data = DW'(seq);
         b.keep = KW'($urandom);
         b.user = UW'($urandom);
         b.last = (i == len - 1);
         tx_q.push_back(b);
      end
   endtask

   // One clock: retire an accepted beat, present the next, pick read_tready.
   task automatic tick();
      @(posedge aclk);
      #1;
      if (wr_acc && tx_q.size() > 0) void'(tx_q.pop_front());
      if (wr_acc || !write_tvalid) begin
         if (tx_q.size() > 0 && ($urandom_range(99) < vprob)) begin
            write_tvalid = 1'b1;
            {write_tdata, write_tkeep, write_tuser, write_tlast} = tx_q[0];
         end else begin
            write_tvalid = 1'b0;
         end
      end
      read_tready = ($urandom_range(99) < rprob);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((tx_q.size() > 0 || write_tvalid || m_comm.size() > 0 || m_pend.size() > 0)
             && n < budget) begin
         tick();
         n++;
      end
      chk("drain_within_budget", 64'(n < budget), 64'(1));
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int rd0, l0, d0;

      // Reset values
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      chk_en = 1'b1;
      chk("rst_write_tready", 64'(write_tready), 64'(1));
      chk("rst_read_tvalid",  64'(read_tvalid),  64'(0));
      chk("rst_fill_level",   64'(fill_level),   64'(0));

      // 3-beat frame with the reader always ready
      vprob = 100; rprob = 100;
      tx_q.push_back(mk(1, 0));
      tx_q.push_back(mk(2, 0));
      tx_q.push_back(mk(3, 1));
      tick();
      tick(); chk("t1_no_early_valid_b1", 64'(read_tvalid), 64'(0));
      tick(); chk("t1_no_early_valid_b2", 64'(read_tvalid), 64'(0));
      tick();
      chk("t1_valid_after_last", 64'(read_tvalid), 64'(1));
      chk("t1_data1", 64'(read_tdata), 64'(1));
      chk("t1_fill3", 64'(fill_level), 64'(3));
      tick();
      chk("t1_data2", 64'(read_tdata), 64'(2));
      chk("t1_fill2", 64'(fill_level), 64'(2));
      tick();
      chk("t1_data3", 64'(read_tdata), 64'(3));
      chk("t1_last3", 64'(read_tlast), 64'(1));
      chk("t1_fill1", 64'(fill_level), 64'(1));
      tick();
      chk("t1_empty_valid", 64'(read_tvalid), 64'(0));
      chk("t1_fill0", 64'(fill_level), 64'(0));

      // Partial frame stays invisible until tlast
      tx_q.push_back(mk(10, 0));
      tx_q.push_back(mk(11, 0));
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("t2_partial_hidden", 64'({read_tvalid, fill_level}), 64'(0));
      end
      rd0 = rd_cnt;
      tx_q.push_back(mk(12, 1));
      drain(50);
      chk("t2_beats_read", 64'(rd_cnt - rd0), 64'(3));

`ifndef AXIS_PKT_FIFO_DROP_EN
      // Fill with 16 single-beat frames, then free one slot
      rprob = 0;
      for (int i = 0; i < 16; i++) tx_q.push_back(mk(DW'(32'h100 + i), 1));
      run(17);
      chk("t3_full_tready", 64'(write_tready), 64'(0));
      chk("t3_full_fill",   64'(fill_level),   64'(16));
      run(2);
      chk("t3_still_full", 64'(write_tready), 64'(0));
      rprob = 100;
      tick();
      rprob = 0;
      tick();
      chk("t3_tready_back", 64'(write_tready), 64'(1));
      chk("t3_fill15",      64'(fill_level),   64'(15));
      rprob = 100;
      drain(100);

      // Oversize frame streams through without deadlock
      rd0 = rd_cnt; l0 = last_cnt;
      push_frame(20);
      drain(300);
      chk("t4_beats_read", 64'(rd_cnt - rd0),   64'(20));
      chk("t4_one_tlast",  64'(last_cnt - l0),  64'(1));
`else
      // Frame B does not fit behind committed frame A and is dropped
      rprob = 0;
      push_frame(10);
      run(12);
      chk("t5_fill_a", 64'(fill_level), 64'(10));
      d0 = drop_cnt;
      push_frame(10);
      run(14);
      chk("t5_fill_kept",  64'(fill_level),     64'(10));
      chk("t5_one_drop",   64'(drop_cnt - d0),  64'(1));
      chk("t5_tready_one", 64'(write_tready),   64'(1));
      rprob = 100;
      rd0 = rd_cnt;
      drain(100);
      chk("t5_a_read", 64'(rd_cnt - rd0), 64'(10));
`endif

      // Reset mid-frame with committed data
      rprob = 0;
      push_frame(5);
      run(8);
      chk("t6_fill5", 64'(fill_level), 64'(5));
      tx_q.push_back(mk(20, 0));
      tx_q.push_back(mk(21, 0));
      tx_q.push_back(mk(22, 0));
      run(3);
      resetn       = 1'b0;
      write_tvalid = 1'b0;
      tx_q.delete();
      tick();
      resetn = 1'b1;
      chk("t6_rst_tready", 64'(write_tready), 64'(1));
      chk("t6_rst_tvalid", 64'(read_tvalid),  64'(0));
      chk("t6_rst_tlast",  64'(read_tlast),   64'(0));
      chk("t6_rst_tdata",  64'(read_tdata),   64'(0));
      chk("t6_rst_tkeep",  64'(read_tkeep),   64'(0));
      chk("t6_rst_tuser",  64'(read_tuser),   64'(0));
      chk("t6_rst_fill",   64'(fill_level),   64'(0));
      chk("t6_rst_drop",   64'(frame_drop),   64'(0));
      rprob = 100;
      tx_q.push_back(mk(32'hABCD, 1));
      tick();
      tick();
      chk("t6_single_valid", 64'(read_tvalid), 64'(1));
      chk("t6_single_data",  64'(read_tdata),  64'(32'hABCD));
      chk("t6_single_last",  64'(read_tlast),  64'(1));
      chk("t6_single_fill",  64'(fill_level),  64'(1));
      tick();
      chk("t6_single_gone", 64'(read_tvalid), 64'(0));

      // Randomized traffic against the model
      for (int r = 0; r < 4; r++) begin
         vprob = $urandom_range(100, 30);
         rprob = $urandom_range(100, 20);
         for (int f = 0; f < 25; f++) begin
            if ($urandom_range(7) == 0) push_frame(int'($urandom_range(24, 9)));
            else                        push_frame(int'($urandom_range(6, 1)));
         end
         drain(6000);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
